// File: rtl/e_mdu_pkg.sv
// e_mdu_pkg: shared opcode/funct constants and MDU op-class encodings for the
// execute-stage multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu on SPECIAL2).
package e_mdu_pkg;

   // Primary opcodes
   localparam logic [5:0] R_TYPE       = 6'b000000;
   localparam logic [5:0] SPECIAL2     = 6'b011100;

   // R-type funct codes handled by the MDU
   localparam logic [5:0] MTHI_FUNCT   = 6'b010001;
   localparam logic [5:0] MTLO_FUNCT   = 6'b010011;
   localparam logic [5:0] MULT_FUNCT   = 6'b011000;
   localparam logic [5:0] MULTU_FUNCT  = 6'b011001;
   localparam logic [5:0] DIV_FUNCT    = 6'b011010;
   localparam logic [5:0] DIVU_FUNCT   = 6'b011011;

   // SPECIAL2 accumulate funct codes; bit 0 = unsigned, bit 2 = subtract
   localparam logic [5:0] MADD_FUNCT   = 6'b000000;
   localparam logic [5:0] MADDU_FUNCT  = 6'b000001;
   localparam logic [5:0] MSUB_FUNCT   = 6'b000100;
   localparam logic [5:0] MSUBU_FUNCT  = 6'b000101;

   // 3-bit MDU op classes; the whole madd family shares one class and the
   // variant is taken from the funct bits by the datapath
   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_MADD  = 3'd7
   } mduOp_e;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mduState_e;

   // True for classes that occupy the unit for several cycles
   function automatic logic isMultiCycle(input mduOp_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU)  ||
             (op == MDU_MADD);
   endfunction

endpackage

// File: rtl/e_mdu_decode.sv
// mdu_decode: purely combinational instruction -> MDU op-class decoder,
// shared by the E-stage MDU and the D-stage hazard unit.
// Optional feature macro: MDU_MADD_EN (enables the SPECIAL2 madd family).
module mdu_decode
   import e_mdu_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [2:0]  opClass_o
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unusedFields;
   mduOp_e     opClass;

   assign opcode       = instr_i[31:26];
   assign funct        = instr_i[5:0];
   assign unusedFields = ^instr_i[25:6];
   assign opClass_o    = opClass;

   // Map opcode/funct to an op class; anything unrecognised is NONE
   always_comb begin
      opClass = MDU_NONE;
      if (opcode == R_TYPE) begin
         case (funct)
            MULT_FUNCT:  opClass = MDU_MULT;
            MULTU_FUNCT: opClass = MDU_MULTU;
            DIV_FUNCT:   opClass = MDU_DIV;
            DIVU_FUNCT:  opClass = MDU_DIVU;
            MTHI_FUNCT:  opClass = MDU_MTHI;
            MTLO_FUNCT:  opClass = MDU_MTLO;
            default:     opClass = MDU_NONE;
         endcase
      end
`ifdef MDU_MADD_EN
      else if (opcode == SPECIAL2) begin
         case (funct)
            MADD_FUNCT, MADDU_FUNCT,
            MSUB_FUNCT, MSUBU_FUNCT: opClass = MDU_MADD;
            default:                 opClass = MDU_NONE;
         endcase
      end
`endif
   end

endmodule

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit owning architectural HI/LO.
// mult/multu/div/divu run for a fixed number of cycles; mthi/mtlo write at the
// next edge. Results are computed at the start edge into pending registers
// and copied into HI/LO when the down-counter expires.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accumulate ops).
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] E_Instr,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   output logic        E_Start,
   output logic        E_Busy,
   output logic [31:0] E_HI,
   output logic [31:0] E_LO
);

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   logic [2:0]  opClassRaw;
   mduOp_e      opClass;

   mduState_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] pHi_q, pHi_d, pLo_q, pLo_d;

   logic [63:0] sProd, uProd;
   logic [31:0] divisor, aMag, bMag, magQuo, magRem;
   logic [31:0] sQuo, sRem, uQuo, uRem;
`ifdef MDU_MADD_EN
   logic [63:0] accAddend, accResult;
`endif

   mdu_decode uDecode (
      .instr_i   (E_Instr),
      .opClass_o (opClassRaw)
   );

   assign opClass = mduOp_e'(opClassRaw);
   assign E_Start = isMultiCycle(opClass);
   assign E_Busy  = (state_q == MDU_BUSY);
   assign E_HI    = hi_q;
   assign E_LO    = lo_q;

   // Datapath: products and quotients from the operands present at the start edge
   always_comb begin
      sProd   = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
      uProd   = {32'd0, E_A} * {32'd0, E_B};
      divisor = (E_B == 32'd0) ? 32'd1 : E_B;
      aMag    = E_A[31] ? (~E_A + 32'd1) : E_A;
      bMag    = E_B[31] ? (~E_B + 32'd1) : divisor;
      magQuo  = aMag / bMag;
      magRem  = aMag % bMag;
      sQuo    = (E_A[31] ^ E_B[31]) ? (~magQuo + 32'd1) : magQuo;
      sRem    = E_A[31] ? (~magRem + 32'd1) : magRem;
      uQuo    = E_A / divisor;
      uRem    = E_A % divisor;
`ifdef MDU_MADD_EN
      accAddend = E_Instr[0] ? uProd : sProd;
      accResult = E_Instr[2] ? ({hi_q, lo_q} - accAddend) : ({hi_q, lo_q} + accAddend);
`endif
   end

   // Next-state logic: start ops and mthi/mtlo in IDLE, count down and commit in BUSY
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pHi_d   = pHi_q;
      pLo_d   = pLo_q;
      case (state_q)
         MDU_IDLE: begin
            case (opClass)
               MDU_MULT: begin
                  pHi_d   = sProd[63:32];
                  pLo_d   = sProd[31:0];
                  cnt_d   = MULT_LOAD;
                  state_d = MDU_BUSY;
               end
               MDU_MULTU: begin
                  pHi_d   = uProd[63:32];
                  pLo_d   = uProd[31:0];
                  cnt_d   = MULT_LOAD;
                  state_d = MDU_BUSY;
               end
               MDU_DIV: begin
                  pHi_d   = (E_B == 32'd0) ? hi_q : sRem;
                  pLo_d   = (E_B == 32'd0) ? lo_q : sQuo;
                  cnt_d   = DIV_LOAD;
                  state_d = MDU_BUSY;
               end
               MDU_DIVU: begin
                  pHi_d   = (E_B == 32'd0) ? hi_q : uRem;
                  pLo_d   = (E_B == 32'd0) ? lo_q : uQuo;
                  cnt_d   = DIV_LOAD;
                  state_d = MDU_BUSY;
               end
`ifdef MDU_MADD_EN
               MDU_MADD: begin
                  pHi_d   = accResult[63:32];
                  pLo_d   = accResult[31:0];
                  cnt_d   = MULT_LOAD;
                  state_d = MDU_BUSY;
               end
`endif
               MDU_MTHI: hi_d = E_A;
               MDU_MTLO: lo_d = E_A;
               default: ;
            endcase
         end
         MDU_BUSY: begin
            if (cnt_q == 4'd0) begin
               hi_d    = pHi_q;
               lo_d    = pLo_q;
               state_d = MDU_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = MDU_IDLE;
      endcase
   end

   // State registers with synchronous reset that also discards any pending result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MDU_IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         pHi_q   <= 32'd0;
         pLo_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pHi_q   <= pHi_d;
         pLo_q   <= pLo_d;
      end
   end

   // An MD op reaching E while busy means the D-stage hazard stall failed
   assert property (@(posedge clk) disable iff (reset)
                    (state_q == MDU_BUSY) |-> (opClass == MDU_NONE))
      else $error("e_mdu: MD op in E while busy, ignored (hazard stall missing)");

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit of the five-stage MIPS pipeline. It decodes the E-stage instruction, runs mult/multu/div/divu with fixed multi-cycle latency, and executes mthi/mtlo immediately. It owns the architectural HI/LO registers. Its HI/LO values travel down the M and W pipeline registers to write-back for mfhi/mflo. Its busy/start outputs feed the D-stage hazard unit.

## Interface
- MULT_CYCLES, 5, cycles E_Busy stays high for mult/multu (and madd family when enabled); legal range 1..15
- DIV_CYCLES, 10, cycles E_Busy stays high for div/divu; legal range 1..15
- clk  input  1  pipeline clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high; clears all state
- E_Instr  input  32  instruction currently in E stage
- E_A  input  32  forwarded rs value
- E_B  input  32  forwarded rt value
- E_Start  output  1  combinational; 1 when E_Instr is a multi-cycle MD op (mult, multu, div, divu, and madd family when enabled)
- E_Busy  output  1  registered; 1 while a multi-cycle op is in flight
- E_HI  output  32  registered architectural HI
- E_LO  output  32  registered architectural LO

## Operation
- Decode classes: MULT, MULTU, DIV, DIVU, MTHI, MTLO, NONE. Any other instruction is NONE.
- FSM has two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
- IDLE, multi-cycle op decoded:
  - compute the result into pending registers p_hi/p_lo;
  - load cnt with MULT_CYCLES-1 or DIV_CYCLES-1;
  - go to BUSY.
- IDLE, MTHI: E_HI <= E_A. IDLE, MTLO: E_LO <= E_A. Both take effect at the next edge and never set busy.
- BUSY: cnt decrements each edge. At cnt==0, E_HI/E_LO <= p_hi/p_lo and the FSM returns to IDLE.
- Any op decoded while BUSY is ignored, including mthi/mtlo. The hazard unit stalls D on (E_Start | E_Busy) for every MD-class instruction, so this case is only reachable through a hazard bug. A simulation-only assertion flags it.
- mult: signed 32x32 to 64-bit product; {HI,LO} = product. multu: the same product, unsigned.
- div: signed, truncates toward zero. LO = quotient; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned division.
- Divide by zero (E_B==0): the op still occupies DIV_CYCLES, but HI/LO are left unchanged at commit.
- Reset, including mid-operation: E_HI=0, E_LO=0, E_Busy=0, FSM=IDLE, cnt=0, p_hi/p_lo=0. The pending result is discarded.

## Timing
- A multi-cycle op is sampled at edge T0. E_Busy=1 during cycles T0+1 .. T0+N, where N is the relevant *_CYCLES value.
- New E_HI/E_LO are visible from T0+N. E_Busy falls in that same cycle, so a back-to-back MD op may be sampled at edge T0+N.
- E_Start has zero latency: it is combinational from E_Instr.
- mthi/mtlo have 1-edge latency.
- E_HI/E_LO hold their old values for the whole BUSY period.

## Configuration
- MDU_MADD_EN defined: SPECIAL2 opcode 011100 additionally decodes four accumulate ops, each with MULT_CYCLES latency:
  - madd, funct 000000: {HI,LO} += signed product;
  - maddu, funct 000001: {HI,LO} += unsigned product;
  - msub, funct 000100: {HI,LO} -= signed product;
  - msubu, funct 000101: {HI,LO} -= unsigned product.
- Accumulation is modulo 2^64 and uses the {HI,LO} value sampled at the start edge.
- MDU_MADD_EN undefined: these encodings decode as NONE; E_Start=0 and HI/LO are untouched.

## Structure
- Opcode/funct constants belong in the shared constant header alongside the existing R_TYPE and *_FUNCT defines:
  - new: MULT/MULTU/DIV/DIVU/MTHI/MTLO funct codes;
  - new: SPECIAL2 opcode and the madd-family functs;
  - new: 3-bit MDU op-class encodings.
- One sub-module, mdu_decode: E_Instr in, op class out, purely combinational. It is also reused by the D-stage hazard unit.

## Test plan
- After reset, apply mult with E_A=0xFFFFFFFE (-2), E_B=3 -> E_Start=1 that cycle; E_Busy high 5 cycles; then E_HI=0xFFFFFFFF, E_LO=0xFFFFFFFA.
- multu with E_A=0xFFFFFFFF, E_B=2 -> after 5 cycles E_HI=0x00000001, E_LO=0xFFFFFFFE.
- div with E_A=-7 (0xFFFFFFF9), E_B=2 -> after 10 cycles E_LO=0xFFFFFFFD (-3), E_HI=0xFFFFFFFF (-1).
  - Follow with divu 7/0 -> busy 10 cycles; HI/LO unchanged.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles -> each visible one edge later; E_Busy stays 0.
  - mthi issued during BUSY -> ignored and the assertion fires.
- Start div, assert reset at busy cycle 4 -> next cycle E_Busy=0, E_HI=E_LO=0, and no later commit.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1*1 -> HI=1, LO=0.
  - Without MDU_MADD_EN: the same instruction leaves HI/LO and E_Start at 0.
